dmr_retry_ctrl: RTL and testbench

Sequential checker and recovery controller on the consuming side of a dual-modular-redundant ALU. It accepts operations over a valid/ready handshake and drives registered operands into an external DMR ALU. It samples the DMR result and mismatch flag, re-executes on mismatch up to a bounded retry count, then returns the result downstream tagged good or faulty. It also keeps saturating error and fault statistics for system health monitoring.

---
 rtl/dmr_pkg.sv | 23 ++
 rtl/dmr_sat_counter.sv | 23 ++
 rtl/dmr_retry_ctrl.sv | 119 +++++++++++
 tb/tb_dmr_retry_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmr_pkg.sv
// Shared definitions for the DMR retry controller: FSM states, ALU opcodes,
// and the default datapath width.
package dmr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        RETRY = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOTA = 3'd5;
    localparam logic [2:0] OP_SHL1 = 3'd6;
    localparam logic [2:0] OP_SHR1 = 3'd7;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/dmr_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module dmr_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    // Count up by one per event, stick at all-ones, clear to zero on demand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmr_retry_ctrl.sv
// Consumer-side checker for a dual-modular-redundant ALU: issues one
// operation at a time, re-executes on a DMR mismatch up to MAX_RETRY times,
// and returns the result tagged good or faulty. Keeps saturating statistics.
module dmr_retry_ctrl
    import dmr_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_RETRY = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_error,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_fault,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] fault_count
);

    // Wide enough to hold 0..MAX_RETRY.
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t          state, state_nxt;
    logic [RW-1:0]   retry_cnt;
    logic            retries_spent;
    logic            mismatch;
    logic            exhausted;

    assign retries_spent = (retry_cnt == RW'(MAX_RETRY));
    assign mismatch      = (state == EXEC) && alu_error;
    assign exhausted     = mismatch && retries_spent;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

    // State register; reset aborts whatever is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: accept -> execute -> (retry gap -> execute)* -> respond.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_valid)                      state_nxt = EXEC;
            EXEC:  if (alu_error && !retries_spent)   state_nxt = RETRY;
                   else                               state_nxt = RESP;
            RETRY:                                    state_nxt = EXEC;
            RESP:  if (out_ready)                     state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    // Operand, retry and response registers; operands hold across retries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            retry_cnt  <= '0;
            out_result <= '0;
            out_fault  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a     <= in_a;
                        alu_b     <= in_b;
                        alu_op    <= in_op;
                        retry_cnt <= '0;
                    end
                end
                EXEC: begin
                    if (!alu_error) begin
                        out_result <= alu_result;
                        out_fault  <= 1'b0;
                    end else if (!retries_spent) begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end else begin
                        // Out of retries: pass the primary result on, flagged.
                        out_result <= alu_result;
                        out_fault  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    dmr_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch),
        .clr   (cnt_clear),
        .count (err_count)
    );

    dmr_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (exhausted),
        .clr   (cnt_clear),
        .count (fault_count)
    );

endmodule

// File: tb/tb_dmr_retry_ctrl.sv
// Directed bench for dmr_retry_ctrl with a behavioural DMR ALU whose
// mismatch flag is scheduled per cycle by the bench.
module tb_dmr_retry_ctrl;
    import dmr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_op;
    logic             alu_error;
    logic             out_valid, out_ready, out_fault;
    logic [WIDTH-1:0] out_result;
    logic             cnt_clear;
    logic [CW-1:0]    err_count, fault_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmr_retry_ctrl #(.WIDTH(WIDTH), .MAX_RETRY(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_error(alu_error),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_fault(out_fault),
        .cnt_clear(cnt_clear),
        .err_count(err_count), .fault_count(fault_count)
    );

    // External ALU: primary result is combinational from the registered operands.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOTA: alu_result = ~alu_a;
            OP_SHL1: alu_result = alu_a << 1;
            OP_SHR1: alu_result = alu_a >> 1;
            default: alu_result = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        tick();
        in_valid = 1'b0;
    endtask

    // EXEC samples fall on even cycles after accept; mask bit i is the
    // mismatch flag for the i-th sample. lat counts edges from the accept edge.
    task automatic wait_resp(input logic [2:0] mask, output int lat);
        int k;
        lat = 1; k = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            alu_error = mask[k/2];
            tick();
            lat++; k++;
        end
        alu_error = 1'b0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0;
        alu_error = 0; out_ready = 0; cnt_clear = 0;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_result !== 8'h00 || out_fault !== 1'b0) begin errors++; $display("FAIL rst_out got %h/%b exp 00/0", out_result, out_fault); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'd0) begin errors++; $display("FAIL rst_alu got %h %h %0d exp 0 0 0", alu_a, alu_b, alu_op); end
        checks++; if (err_count !== 2'd0 || fault_count !== 2'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", err_count, fault_count); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_clean_add();
        int lat;
        issue(8'h0F, 8'h01, OP_ADD);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clean_in_ready_drop got %b exp 0", in_ready); end
        wait_resp(3'b000, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL clean_latency got %0d exp 2", lat); end
        checks++; if (out_result !== 8'h10 || out_fault !== 1'b0) begin errors++; $display("FAIL clean_result got %h/%b exp 10/0", out_result, out_fault); end
        checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL clean_err_count got %0d exp 0", err_count); end
        ack();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clean_handshake got v=%b r=%b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_transient();
        int lat;
        issue(8'h33, 8'h0F, OP_XOR);
        wait_resp(3'b001, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL transient_latency got %0d exp 4", lat); end
        checks++; if (out_result !== 8'h3C || out_fault !== 1'b0) begin errors++; $display("FAIL transient_result got %h/%b exp 3c/0", out_result, out_fault); end
        checks++; if (err_count !== 2'd1 || fault_count !== 2'd0) begin errors++; $display("FAIL transient_counts got %0d/%0d exp 1/0", err_count, fault_count); end
        ack();
    endtask

    task automatic test_persistent();
        int lat;
        clear_counts();
        issue(8'h80, 8'h00, OP_SHR1);
        wait_resp(3'b111, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL persistent_latency got %0d exp 6", lat); end
        checks++; if (out_result !== 8'h40 || out_fault !== 1'b1) begin errors++; $display("FAIL persistent_result got %h/%b exp 40/1", out_result, out_fault); end
        checks++; if (err_count !== 2'd3 || fault_count !== 2'd1) begin errors++; $display("FAIL persistent_counts got %0d/%0d exp 3/1", err_count, fault_count); end
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        issue(8'hF0, 8'h3C, OP_AND);
        wait_resp(3'b000, lat);
        // A competing request appears while the response is stalled.
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_op = OP_ADD;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_result !== 8'h30 || out_fault !== 1'b0 ||
                in_ready !== 1'b0 || alu_a !== 8'hF0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got r=%b v=%b exp 1/0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || alu_a !== 8'h11 || alu_b !== 8'h22) begin errors++; $display("FAIL bp_accept got r=%b a=%h b=%h exp 0/11/22", in_ready, alu_a, alu_b); end
        wait_resp(3'b000, lat);
        checks++; if (lat !== 2 || out_result !== 8'h33) begin errors++; $display("FAIL bp_second got lat=%0d res=%h exp 2/33", lat, out_result); end
        ack();
    endtask

    task automatic test_saturation();
        int lat;
        clear_counts();
        issue(8'h01, 8'h01, OP_SUB);
        wait_resp(3'b111, lat);
        ack();
        checks++; if (err_count !== 2'd3) begin errors++; $display("FAIL sat_three got %0d exp 3", err_count); end
        issue(8'h0A, 8'h05, OP_OR);
        wait_resp(3'b001, lat);
        ack();
        issue(8'h55, 8'h00, OP_NOTA);
        wait_resp(3'b001, lat);
        checks++; if (err_count !== 2'd3 || fault_count !== 2'd1) begin errors++; $display("FAIL sat_five got %0d/%0d exp 3/1", err_count, fault_count); end
        checks++; if (out_result !== 8'hAA) begin errors++; $display("FAIL sat_nota got %h exp aa", out_result); end
        ack();
        // Clear lands on the same edge as a mismatch sample.
        issue(8'h81, 8'h00, OP_SHL1);
        alu_error = 1'b1; cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        checks++; if (err_count !== 2'd0 || fault_count !== 2'd0) begin errors++; $display("FAIL clr_priority got %0d/%0d exp 0/0", err_count, fault_count); end
        wait_resp(3'b111, lat);
        checks++; if (err_count !== 2'd2 || fault_count !== 2'd1 || out_fault !== 1'b1 || out_result !== 8'h02) begin errors++; $display("FAIL clr_after got %0d/%0d f=%b r=%h exp 2/1/1/02", err_count, fault_count, out_fault, out_result); end
        ack();
    endtask

    task automatic test_reset_mid_retry();
        int lat;
        int seen;
        issue(8'h12, 8'h34, OP_ADD);
        alu_error = 1'b1;
        tick();
        // Controller is now in RETRY with one mismatch counted.
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_immediate got v=%b r=%b exp 0/1", out_valid, in_ready); end
        checks++; if (err_count !== 2'd0 || fault_count !== 2'd0 || alu_a !== 8'h00) begin errors++; $display("FAIL midrst_clear got %0d/%0d a=%h exp 0/0/00", err_count, fault_count, alu_a); end
        alu_error = 1'b0;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_resp got %0d valid cycles exp 0", seen); end
        issue(8'h0F, 8'h01, OP_ADD);
        wait_resp(3'b000, lat);
        checks++; if (lat !== 2 || out_result !== 8'h10 || out_fault !== 1'b0 || err_count !== 2'd0) begin errors++; $display("FAIL midrst_clean got lat=%0d r=%h f=%b e=%0d exp 2/10/0/0", lat, out_result, out_fault, err_count); end
        ack();
    endtask

    initial begin
        test_reset();
        test_clean_add();
        test_transient();
        test_persistent();
        test_backpressure();
        test_saturation();
        test_reset_mid_retry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
